// File: rtl/cache_miss_ctrl.sv
// Miss/hit sequencing controller for a 2-way set-associative L1 cache:
// lookup, victim writeback, refill, install and response, one request at a time.
module cache_miss_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 512,
   parameter int SETS       = 128,
   localparam int OFF       = $clog2(LINE_WIDTH / 8),
   localparam int IDX       = $clog2(SETS),
   localparam int TAG       = ADDR_WIDTH - IDX - OFF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [LINE_WIDTH-1:0]   rsp_line_o,
   output logic [IDX-1:0]          set_index_o,
   input  logic                    hit_i,
   input  logic                    hit_way_i,
   input  logic [LINE_WIDTH-1:0]   hit_line_i,
   input  logic [1:0]              way_valid_i,
   input  logic [1:0]              way_dirty_i,
   input  logic [2*TAG-1:0]        way_tag_i,
   input  logic [2*LINE_WIDTH-1:0] way_line_i,
   input  logic                    victim_way_i,
   output logic                    lru_hit_o,
   output logic                    lru_miss_o,
   output logic                    lru_way_o,
   output logic                    mem_req_valid_o,
   input  logic                    mem_req_ready_i,
   output logic                    mem_req_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
   output logic [LINE_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_rvalid_i,
   input  logic [LINE_WIDTH-1:0]   mem_rdata_i,
   output logic                    fill_we_o,
   output logic                    fill_way_o,
   output logic [TAG-1:0]          fill_tag_o,
   output logic [LINE_WIDTH-1:0]   fill_line_o,
   output logic [31:0]             hit_count_o,
   output logic [31:0]             miss_count_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB_REQ, S_RF_REQ, S_RF_WAIT, S_INSTALL, S_RESPOND
   } state_e;

   state_e                  r_state;
   logic                    r_req_ready;
   logic [TAG-1:0]          r_req_tag;
   logic [IDX-1:0]          r_set_index;
   logic                    r_vic_way;
   logic                    r_rsp_valid;
   logic [LINE_WIDTH-1:0]   r_rsp_line;
   logic                    r_lru_hit;
   logic                    r_lru_miss;
   logic                    r_lru_way;
   logic                    r_mem_valid;
   logic                    r_mem_we;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [LINE_WIDTH-1:0]   r_mem_wdata;
   logic                    r_fill_we;
   logic                    r_fill_way;
   logic [TAG-1:0]          r_fill_tag;
   logic [LINE_WIDTH-1:0]   r_fill_line;
   logic [31:0]             r_hit_count;
   logic [31:0]             r_miss_count;

   logic                    w_vic_way;
   logic                    w_vic_dirty;
   logic [TAG-1:0]          w_vic_tag;
   logic [LINE_WIDTH-1:0]   w_vic_line;
   logic [ADDR_WIDTH-1:0]   w_refill_addr;
   logic                    w_unused_offset;

   // Invalid ways are filled first (way 0 before way 1); the policy only decides between two valid ways.
   always_comb begin
      w_vic_way = victim_way_i;
      if (!way_valid_i[0]) begin
         w_vic_way = 1'b0;
      end else if (!way_valid_i[1]) begin
         w_vic_way = 1'b1;
      end
   end

   assign w_vic_tag       = w_vic_way ? way_tag_i[2*TAG-1:TAG] : way_tag_i[TAG-1:0];
   assign w_vic_line      = w_vic_way ? way_line_i[2*LINE_WIDTH-1:LINE_WIDTH]
                                      : way_line_i[LINE_WIDTH-1:0];
   assign w_vic_dirty     = way_valid_i[w_vic_way] & way_dirty_i[w_vic_way];
   assign w_refill_addr   = {r_req_tag, r_set_index, {OFF{1'b0}}};
   assign w_unused_offset = ^req_addr_i[OFF-1:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_req_tag    <= '0;
         r_set_index  <= '0;
         r_vic_way    <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_line   <= '0;
         r_lru_hit    <= 1'b0;
         r_lru_miss   <= 1'b0;
         r_lru_way    <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_fill_we    <= 1'b0;
         r_fill_way   <= 1'b0;
         r_fill_tag   <= '0;
         r_fill_line  <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_lru_hit  <= 1'b0;
         r_lru_miss <= 1'b0;
         r_fill_we  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_req_ready <= 1'b0;
                  r_req_tag   <= req_addr_i[ADDR_WIDTH-1 -: TAG];
                  r_set_index <= req_addr_i[OFF +: IDX];
                  r_state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit_i) begin
                  r_lru_hit   <= 1'b1;
                  r_lru_way   <= hit_way_i;
                  r_rsp_line  <= hit_line_i;
                  r_rsp_valid <= 1'b1;
                  if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
                  r_state     <= S_RESPOND;
               end else begin
                  r_vic_way   <= w_vic_way;
                  r_mem_wdata <= w_vic_line;
                  r_mem_valid <= 1'b1;
                  if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
                  if (w_vic_dirty) begin
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= {w_vic_tag, r_set_index, {OFF{1'b0}}};
                     r_state    <= S_WB_REQ;
                  end else begin
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= w_refill_addr;
                     r_state    <= S_RF_REQ;
                  end
               end
            end
            S_WB_REQ: begin
               // Writeback is posted: the refill request follows directly without a response.
               if (mem_req_ready_i) begin
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_refill_addr;
                  r_state    <= S_RF_REQ;
               end
            end
            S_RF_REQ: begin
               if (mem_req_ready_i) begin
                  r_mem_valid <= 1'b0;
                  r_state     <= S_RF_WAIT;
               end
            end
            S_RF_WAIT: begin
               if (mem_rvalid_i) begin
                  r_fill_line <= mem_rdata_i;
                  r_fill_we   <= 1'b1;
                  r_fill_way  <= r_vic_way;
                  r_fill_tag  <= r_req_tag;
                  r_state     <= S_INSTALL;
               end
            end
            S_INSTALL: begin
               r_lru_miss  <= 1'b1;
               r_lru_way   <= r_vic_way;
               r_rsp_line  <= r_fill_line;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESPOND;
            end
            S_RESPOND: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o     = r_req_ready;
   assign rsp_valid_o     = r_rsp_valid;
   assign rsp_line_o      = r_rsp_line;
   assign set_index_o     = r_set_index;
   assign lru_hit_o       = r_lru_hit;
   assign lru_miss_o      = r_lru_miss;
   assign lru_way_o       = r_lru_way;
   assign mem_req_valid_o = r_mem_valid;
   assign mem_req_we_o    = r_mem_we;
   assign mem_req_addr_o  = r_mem_addr;
   assign mem_wdata_o     = r_mem_wdata;
   assign fill_we_o       = r_fill_we;
   assign fill_way_o      = r_fill_way;
   assign fill_tag_o      = r_fill_tag;
   assign fill_line_o     = r_fill_line;
   assign hit_count_o     = r_hit_count;
   assign miss_count_o    = r_miss_count;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed and random transactions
// against a transaction-level reference of the lookup/writeback/refill rules.
module tb_cache_miss_ctrl;

   localparam int AW   = 32;
   localparam int LW   = 512;
   localparam int SETS = 128;
   localparam int OFF  = 6;
   localparam int IDX  = 7;
   localparam int TAG  = 19;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              req_valid_i, req_ready_o;
   logic [AW-1:0]     req_addr_i;
   logic              rsp_valid_o, rsp_ready_i;
   logic [LW-1:0]     rsp_line_o;
   logic [IDX-1:0]    set_index_o;
   logic              hit_i, hit_way_i;
   logic [LW-1:0]     hit_line_i;
   logic [1:0]        way_valid_i, way_dirty_i;
   logic [2*TAG-1:0]  way_tag_i;
   logic [2*LW-1:0]   way_line_i;
   logic              victim_way_i;
   logic              lru_hit_o, lru_miss_o, lru_way_o;
   logic              mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
   logic [AW-1:0]     mem_req_addr_o;
   logic [LW-1:0]     mem_wdata_o;
   logic              mem_rvalid_i;
   logic [LW-1:0]     mem_rdata_i;
   logic              fill_we_o, fill_way_o;
   logic [TAG-1:0]    fill_tag_o;
   logic [LW-1:0]     fill_line_o;
   logic [31:0]       hit_count_o, miss_count_o;

   int                n_checks = 0;
   int                n_err = 0;
   logic [31:0]       m_hits = '0;
   logic [31:0]       m_miss = '0;

   cache_miss_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .SETS(SETS)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_line_o(rsp_line_o),
      .set_index_o(set_index_o),
      .hit_i(hit_i), .hit_way_i(hit_way_i), .hit_line_i(hit_line_i),
      .way_valid_i(way_valid_i), .way_dirty_i(way_dirty_i), .way_tag_i(way_tag_i),
      .way_line_i(way_line_i), .victim_way_i(victim_way_i),
      .lru_hit_o(lru_hit_o), .lru_miss_o(lru_miss_o), .lru_way_o(lru_way_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .fill_we_o(fill_we_o), .fill_way_o(fill_way_o), .fill_tag_o(fill_tag_o),
      .fill_line_o(fill_line_o), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of run, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic scramble_lookup();
      hit_i        = 1'($urandom());
      hit_way_i    = 1'($urandom());
      hit_line_i   = rand_line();
      way_valid_i  = 2'($urandom());
      way_dirty_i  = 2'($urandom());
      way_tag_i    = {7'($urandom()), 31'($urandom())};
      way_line_i   = {rand_line(), rand_line()};
      victim_way_i = 1'($urandom());
   endtask

   // One memory request phase; stray read responses are injected while it is stalled.
   task automatic mem_phase(input string nm, input logic we, input logic [AW-1:0] a,
                            input logic chkdata, input logic [LW-1:0] d, input int stall);
      logic [LW-1:0] w0;
      w0 = mem_wdata_o;
      for (int i = 0; i <= stall; i++) begin
         chk({nm, "_valid"}, mem_req_valid_o, 1);
         chk({nm, "_we"}, mem_req_we_o, we);
         chk({nm, "_addr"}, mem_req_addr_o, a);
         chk({nm, "_wdata"}, mem_wdata_o, chkdata ? d : w0);
         chk({nm, "_no_fill"}, fill_we_o, 0);
         mem_req_ready_i = (i == stall);
         mem_rvalid_i    = (i != stall) ? 1'($urandom()) : 1'b0;
         mem_rdata_i     = rand_line();
         tick();
      end
      mem_req_ready_i = 1'b0;
      mem_rvalid_i    = 1'b0;
   endtask

   task automatic run_txn(input logic [AW-1:0] addr, input logic hit, input logic hway,
                          input logic [1:0] vld, input logic [1:0] dty,
                          input logic [2*TAG-1:0] tags, input logic vict_in,
                          input int wb_stall, input int rf_stall, input int rv_wait,
                          input int rsp_wait, input logic abort);
      logic [LW-1:0]  hline, l0, l1, rdata, vline, exp_line;
      logic [TAG-1:0] rtag, vtag;
      logic [IDX-1:0] idx;
      logic           vway, do_wb;
      hline = rand_line();
      l0    = rand_line();
      l1    = rand_line();
      rdata = rand_line();
      rtag  = addr[AW-1 -: TAG];
      idx   = addr[OFF +: IDX];
      if (!vld[0])      vway = 1'b0;
      else if (!vld[1]) vway = 1'b1;
      else              vway = vict_in;
      vtag  = vway ? tags[2*TAG-1:TAG] : tags[TAG-1:0];
      vline = vway ? l1 : l0;
      do_wb = vld[vway] && dty[vway];

      chk("req_ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      tick();
      req_valid_i = 1'b0;
      req_addr_i  = $urandom();
      chk("req_ready_busy", req_ready_o, 0);
      chk("set_index", set_index_o, idx);
      chk("rsp_early", rsp_valid_o, 0);
      hit_i = hit; hit_way_i = hway; hit_line_i = hline;
      way_valid_i = vld; way_dirty_i = dty; way_tag_i = tags;
      way_line_i = {l1, l0}; victim_way_i = vict_in;
      tick();
      scramble_lookup();

      if (hit) begin
         m_hits = sat(m_hits);
         chk("lru_hit", lru_hit_o, 1);
         chk("lru_hit_way", lru_way_o, hway);
         chk("lru_miss_on_hit", lru_miss_o, 0);
         chk("mem_on_hit", mem_req_valid_o, 0);
         chk("fill_on_hit", fill_we_o, 0);
         chk("hit_count", hit_count_o, m_hits);
         chk("miss_count_hit", miss_count_o, m_miss);
         exp_line = hline;
      end else begin
         m_miss = sat(m_miss);
         chk("miss_count", miss_count_o, m_miss);
         chk("hit_count_miss", hit_count_o, m_hits);
         chk("lru_hit_on_miss", lru_hit_o, 0);
         chk("rsp_on_miss", rsp_valid_o, 0);
         if (do_wb) mem_phase("wb", 1'b1, {vtag, idx, 6'b0}, 1'b1, vline, wb_stall);
         mem_phase("rf", 1'b0, {rtag, idx, 6'b0}, 1'b0, '0, rf_stall);
         chk("rf_wait_idle", mem_req_valid_o, 0);
         if (abort) begin
            #2 rst_ni = 1'b0;
            #1;
            m_hits = '0;
            m_miss = '0;
            chk("rst_req_ready", req_ready_o, 1);
            chk("rst_mem_valid", mem_req_valid_o, 0);
            chk("rst_miss_count", miss_count_o, m_miss);
            chk("rst_set_index", set_index_o, 0);
            tick();
            rst_ni       = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata;
            tick();
            mem_rvalid_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
               chk("stray_fill", fill_we_o, 0);
               chk("stray_rsp", rsp_valid_o, 0);
               chk("stray_ready", req_ready_o, 1);
               tick();
            end
            return;
         end
         for (int i = 0; i < rv_wait; i++) begin
            chk("rf_wait_fill", fill_we_o, 0);
            mem_rdata_i = rand_line();
            tick();
         end
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = rdata;
         tick();
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = rand_line();
         chk("fill_we", fill_we_o, 1);
         chk("fill_way", fill_way_o, vway);
         chk("fill_tag", fill_tag_o, rtag);
         chk("fill_line", fill_line_o, rdata);
         chk("lru_miss_early", lru_miss_o, 0);
         chk("rsp_in_install", rsp_valid_o, 0);
         tick();
         chk("fill_we_pulse", fill_we_o, 0);
         chk("lru_miss", lru_miss_o, 1);
         chk("lru_miss_way", lru_way_o, vway);
         chk("lru_hit_in_miss", lru_hit_o, 0);
         exp_line = rdata;
      end

      for (int i = 0; i <= rsp_wait; i++) begin
         chk("rsp_valid", rsp_valid_o, 1);
         chk("rsp_line", rsp_line_o, exp_line);
         chk("set_index_rsp", set_index_o, idx);
         rsp_ready_i = (i == rsp_wait);
         tick();
         if (i == 0) begin
            chk("lru_hit_single", lru_hit_o, 0);
            chk("lru_miss_single", lru_miss_o, 0);
         end
      end
      rsp_ready_i = 1'b0;
      chk("rsp_done", rsp_valid_o, 0);
      chk("req_ready_back", req_ready_o, 1);
   endtask

   initial begin
      req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b0;
      hit_i = 1'b0; hit_way_i = 1'b0; hit_line_i = '0;
      way_valid_i = '0; way_dirty_i = '0; way_tag_i = '0; way_line_i = '0;
      victim_way_i = 1'b0; mem_req_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      repeat (3) tick();
      chk("reset_req_ready", req_ready_o, 1);
      chk("reset_rsp_valid", rsp_valid_o, 0);
      chk("reset_rsp_line", rsp_line_o, 0);
      chk("reset_mem_valid", mem_req_valid_o, 0);
      chk("reset_fill_we", fill_we_o, 0);
      chk("reset_lru", {lru_hit_o, lru_miss_o, lru_way_o}, 0);
      chk("reset_set_index", set_index_o, 0);
      chk("reset_hit_count", hit_count_o, 0);
      chk("reset_miss_count", miss_count_o, 0);
      rst_ni = 1'b1;
      tick();

      run_txn(32'h0000_1040, 1'b1, 1'b1, 2'b11, 2'b00, {19'h1, 19'h0}, 1'b0, 0, 0, 0, 0, 1'b0);
      run_txn(32'h0000_2080, 1'b0, 1'b0, 2'b10, 2'b11, {19'h7, 19'h9}, 1'b1, 0, 0, 2, 1, 1'b0);
      run_txn(32'h0003_0C40, 1'b0, 1'b0, 2'b11, 2'b10, {19'h5, 19'h3}, 1'b1, 5, 5, 3, 2, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_txn($urandom(), ($urandom_range(0, 2) == 0), 1'($urandom()), 2'($urandom()),
                 2'($urandom()), {7'($urandom()), 31'($urandom())}, 1'($urandom()),
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
                 $urandom_range(0, 3), 1'b0);
      end

      run_txn($urandom(), 1'b0, 1'b0, 2'b11, 2'b11, {7'($urandom()), 31'($urandom())},
              1'b0, 1, 2, 0, 0, 1'b1);

      force dut.r_miss_count = 32'hFFFF_FFFF;
      force dut.r_hit_count  = 32'hFFFF_FFFE;
      tick();
      release dut.r_miss_count;
      release dut.r_hit_count;
      m_miss = 32'hFFFF_FFFF;
      m_hits = 32'hFFFF_FFFE;
      tick();
      chk("preload_miss", miss_count_o, m_miss);
      run_txn(32'h0000_4000, 1'b0, 1'b0, 2'b01, 2'b00, {19'h2, 19'h4}, 1'b0, 0, 1, 1, 0, 1'b0);
      run_txn(32'h0000_4040, 1'b1, 1'b0, 2'b11, 2'b00, {19'h2, 19'h4}, 1'b0, 0, 0, 0, 0, 1'b0);
      run_txn(32'h0000_4080, 1'b1, 1'b1, 2'b11, 2'b00, {19'h2, 19'h4}, 1'b0, 0, 0, 0, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
